// File: rtl/uart_tx_fifo_top.sv
// UART transmit path: FIFO message buffer feeding a framing FSM.
// Ports: clk, rst (sync, active high), wr_en/wr_data (push),
//   full/empty/level (FIFO status), overflow (sticky drop flag),
//   tx_busy (frame in progress), tx_serial (registered line, idle high).
module uart_tx_fifo_top #(
   parameter int CLK_DIV    = 10,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              wr_en,
   input  logic [DATA_BITS-1:0]              wr_data,
   output logic                              full,
   output logic                              empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
   output logic                              overflow,
   output logic                              tx_busy,
   output logic                              tx_serial
);

   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int LW       = $clog2(FIFO_DEPTH + 1);
   localparam int STOP_LEN = STOP_BITS * CLK_DIV;
   localparam int CW       = $clog2(STOP_LEN);
   localparam int BW       = $clog2(DATA_BITS);

   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [LW-1:0]        count;
   logic                 push;
   logic                 pop;

   // Framing FSM state
   state_t               state, state_n;
   logic [CW-1:0]        baud, baud_n;
   logic [BW-1:0]        bit_idx, bit_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [DATA_BITS-1:0] data_q, data_n;
   logic                 tx_q, tx_n;
   logic                 par_bit;

   assign full      = (count == DEPTH_L);
   assign empty     = (count == '0);
   assign level     = count;
   // full is the pre-pop value, so a write while full drops even on a pop
   assign push      = wr_en && !full;
   assign tx_busy   = (state != IDLE);
   assign tx_serial = tx_q;

   // Parity comes from the latched payload, not the FIFO head
   assign par_bit   = (PARITY == 2) ? ~(^data_q) : ^data_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         data_q  <= '0;
         tx_q    <= 1'b1;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_n;
         shreg   <= shreg_n;
         data_q  <= data_n;
         tx_q    <= tx_n;
      end
   end

   // tx_n is the line value for the state being entered,
   // so tx_serial changes on the same edge as the state.
   always_comb begin
      state_n = state;
      baud_n  = baud + CW'(1);
      bit_n   = bit_idx;
      shreg_n = shreg;
      data_n  = data_q;
      tx_n    = tx_q;
      pop     = 1'b0;
      unique case (state)
         IDLE: begin
            baud_n = '0;
            tx_n   = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               data_n  = mem[rd_ptr];
               shreg_n = mem[rd_ptr];
               bit_n   = '0;
               state_n = START;
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (baud == BIT_LAST) begin
               baud_n  = '0;
               state_n = DATA;
               tx_n    = shreg[0];
            end
         end
         DATA: begin
            if (baud == BIT_LAST) begin
               baud_n = '0;
               if (bit_idx == DATA_LAST) begin
                  if (PARITY != 0) begin
                     state_n = PAR;
                     tx_n    = par_bit;
                  end else begin
                     state_n = STOP;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bit_n   = bit_idx + BW'(1);
                  shreg_n = shreg >> 1;
                  tx_n    = shreg[1];
               end
            end
         end
         PAR: begin
            if (baud == BIT_LAST) begin
               baud_n  = '0;
               state_n = STOP;
               tx_n    = 1'b1;
            end
         end
         STOP: begin
            if (baud == STOP_LAST) begin
               baud_n = '0;
               // back-to-back frames: reload directly, no idle gap
               if (!empty) begin
                  pop     = 1'b1;
                  data_n  = mem[rd_ptr];
                  shreg_n = mem[rd_ptr];
                  bit_n   = '0;
                  state_n = START;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
                  tx_n    = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo_top.sv
// Bench for uart_tx_fifo_top: four parameter sets driven together,
// checked each cycle against a frame/queue level model.
module tb_uart_tx_fifo_top;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] rst_v = 4'hF;
   logic [3:0] we_v  = 4'h0;
   logic [7:0] wd_v [4];
   logic [3:0] full_v, empty_v, ovf_v, busy_v, tx_v;
   logic [2:0] lvl_v [4];

   int total = 0;
   int bad   = 0;

   int cdv  [4] = '{4, 4, 4, 3};
   int parv [4] = '{0, 1, 2, 1};
   int sbv  [4] = '{1, 1, 1, 2};

   logic [7:0] mq [4][$];
   bit         wv [4][$];
   bit         movf [4];
   bit         ha[$], hb[$], hc[$], hd[$];

   uart_tx_fifo_top #(.CLK_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4),
                      .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst(rst_v[0]), .wr_en(we_v[0]), .wr_data(wd_v[0]),
      .full(full_v[0]), .empty(empty_v[0]), .level(lvl_v[0]),
      .overflow(ovf_v[0]), .tx_busy(busy_v[0]), .tx_serial(tx_v[0]));

   uart_tx_fifo_top #(.CLK_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4),
                      .PARITY(1), .STOP_BITS(1)) u_b (
      .clk(clk), .rst(rst_v[1]), .wr_en(we_v[1]), .wr_data(wd_v[1]),
      .full(full_v[1]), .empty(empty_v[1]), .level(lvl_v[1]),
      .overflow(ovf_v[1]), .tx_busy(busy_v[1]), .tx_serial(tx_v[1]));

   uart_tx_fifo_top #(.CLK_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4),
                      .PARITY(2), .STOP_BITS(1)) u_c (
      .clk(clk), .rst(rst_v[2]), .wr_en(we_v[2]), .wr_data(wd_v[2]),
      .full(full_v[2]), .empty(empty_v[2]), .level(lvl_v[2]),
      .overflow(ovf_v[2]), .tx_busy(busy_v[2]), .tx_serial(tx_v[2]));

   uart_tx_fifo_top #(.CLK_DIV(3), .DATA_BITS(8), .FIFO_DEPTH(4),
                      .PARITY(1), .STOP_BITS(2)) u_d (
      .clk(clk), .rst(rst_v[3]), .wr_en(we_v[3]), .wr_data(wd_v[3]),
      .full(full_v[3]), .empty(empty_v[3]), .level(lvl_v[3]),
      .overflow(ovf_v[3]), .tx_busy(busy_v[3]), .tx_serial(tx_v[3]));

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Expected line waveform of one whole frame, one entry per clock
   task automatic start_frame(int i, logic [7:0] b);
      bit bits[$];
      bit p;
      bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) bits.push_back(b[j]);
      if (parv[i] != 0) begin
         p = ^b;
         if (parv[i] == 2) p = ~p;
         bits.push_back(p);
      end
      for (int s = 0; s < sbv[i]; s++) bits.push_back(1'b1);
      foreach (bits[k])
         for (int c = 0; c < cdv[i]; c++) wv[i].push_back(bits[k]);
   endtask

   task automatic model_step();
      for (int i = 0; i < 4; i++) begin
         bit fb;
         fb = (mq[i].size() == 4);
         if (rst_v[i]) begin
            mq[i].delete();
            wv[i].delete();
            movf[i] = 1'b0;
         end else begin
            if (wv[i].size() > 0) void'(wv[i].pop_front());
            if (wv[i].size() == 0 && mq[i].size() > 0)
               start_frame(i, mq[i].pop_front());
            if (we_v[i]) begin
               if (fb) movf[i] = 1'b1;
               else mq[i].push_back(wd_v[i]);
            end
         end
      end
   endtask

   task automatic compare();
      for (int i = 0; i < 4; i++) begin
         string t;
         int    etx;
         t   = $sformatf("u%0d", i);
         etx = (wv[i].size() > 0) ? int'(wv[i][0]) : 1;
         chk({t, "_tx"},    int'(tx_v[i]),    etx);
         chk({t, "_busy"},  int'(busy_v[i]),  int'(wv[i].size() > 0));
         chk({t, "_level"}, int'(lvl_v[i]),   mq[i].size());
         chk({t, "_empty"}, int'(empty_v[i]), int'(mq[i].size() == 0));
         chk({t, "_full"},  int'(full_v[i]),  int'(mq[i].size() == 4));
         chk({t, "_ovf"},   int'(ovf_v[i]),   int'(movf[i]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare();
      ha.push_back(tx_v[0]);
      hb.push_back(tx_v[1]);
      hc.push_back(tx_v[2]);
      hd.push_back(tx_v[3]);
   endtask

   initial begin
      bit [9:0] pat;
      int       nb;
      int       z;
      int       ones;
      int       idx;
      for (int i = 0; i < 4; i++) wd_v[i] = 8'h00;

      // reset held three cycles
      repeat (3) tick();
      for (int i = 0; i < 4; i++) begin
         chk("rst_tx",    int'(tx_v[i]),    1);
         chk("rst_empty", int'(empty_v[i]), 1);
         chk("rst_level", int'(lvl_v[i]),   0);
         chk("rst_busy",  int'(busy_v[i]),  0);
         chk("rst_ovf",   int'(ovf_v[i]),   0);
      end
      rst_v = 4'h0;
      tick();

      // 0xA5 8N1, 0x07 even/odd parity, two 0x00 frames with 2 stops
      we_v = 4'hF;
      wd_v = '{8'hA5, 8'h07, 8'h07, 8'h00};
      tick();
      ha.delete(); hb.delete(); hc.delete(); hd.delete();
      we_v = 4'b1000;
      nb = 0;
      tick();
      nb += int'(busy_v[0]);
      we_v = 4'h0;
      repeat (79) begin
         tick();
         nb += int'(busy_v[0]);
      end
      pat = 10'b11_0100_1010;
      for (int j = 0; j < 10; j++)
         chk($sformatf("a5_bit%0d", j), int'(ha[4*j+1]), int'(pat[j]));
      chk("a5_busy_cycles", nb, 40);
      chk("even_07", int'(hb[37]), 1);
      chk("odd_07",  int'(hc[37]), 0);

      z = 0; ones = 0; idx = 0;
      while (idx < hd.size() && hd[idx] == 1'b0) begin
         z++; idx++;
      end
      while (idx < hd.size() && hd[idx] == 1'b1) begin
         ones++; idx++;
      end
      chk("stop2_low_run",  z,    30);
      chk("stop2_high_gap", ones, 6);

      // 0x03 parity
      we_v = 4'b0110;
      wd_v[1] = 8'h03;
      wd_v[2] = 8'h03;
      tick();
      ha.delete(); hb.delete(); hc.delete(); hd.delete();
      we_v = 4'h0;
      repeat (45) tick();
      chk("even_03", int'(hb[37]), 0);
      chk("odd_03",  int'(hc[37]), 1);

      // burst of 6 into a depth-4 FIFO
      nb = 0;
      for (int k = 0; k < 6; k++) begin
         we_v = 4'b0001;
         wd_v[0] = 8'h11 + 8'(k);
         tick();
         nb += int'(busy_v[0]);
      end
      we_v = 4'h0;
      chk("burst_full",  int'(full_v[0]), 1);
      chk("burst_level", int'(lvl_v[0]),  4);
      chk("burst_ovf",   int'(ovf_v[0]),  1);
      repeat (210) begin
         tick();
         nb += int'(busy_v[0]);
      end
      chk("burst_busy_cycles", nb, 200);

      // reset in the middle of frame 2 of 3
      for (int k = 0; k < 3; k++) begin
         we_v = 4'b0001;
         wd_v[0] = 8'h31 + 8'(k);
         tick();
      end
      we_v = 4'h0;
      repeat (45) tick();
      chk("mid_busy", int'(busy_v[0]), 1);
      rst_v = 4'b0001;
      tick();
      chk("abort_tx",    int'(tx_v[0]),   1);
      chk("abort_level", int'(lvl_v[0]),  0);
      chk("abort_busy",  int'(busy_v[0]), 0);
      rst_v = 4'h0;
      nb = 0;
      repeat (60) begin
         tick();
         nb += int'(busy_v[0]);
      end
      chk("abort_no_frames", nb, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
